// File: rtl/req_scheduler16_pkg.sv
// Shared types and constants for the 16-input request scheduler and its
// scanned two-digit 7-segment display.
package req_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g, bit 7 = dp
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Any BCD value above 9 decodes to a blank digit
    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam logic [1:0] DIGSEL_ONES = 2'b10;
    localparam logic [1:0] DIGSEL_TENS = 2'b01;

endpackage

// File: rtl/req_scheduler16_seg7_decode.sv
// BCD to 7-segment decoder; inputs above 9 blank the digit.
module seg7_decode
    import req_sched_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/req_scheduler16.sv
// 16-input priority request scheduler: grants the highest unmasked active-low
// request, holds it until ack/withdraw/timeout/abort, and scans the index out.
//
//   state   | meaning
//   IDLE    | no grant, waiting for an enabled unmasked request
//   GRANT   | Valid high, Code held, grant timer running
//   RELEASE | one-cycle gap after a grant ends
module req_scheduler16
    import req_sched_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EI,
    input  logic [15:0] ReqIn,
    input  logic        Ack,
    output logic        Valid,
    output logic [3:0]  Code,
    output logic        Timeout,
    output logic [7:0]  Seg,
    output logic [1:0]  DigSel
);

    localparam int TW = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(GRANT_TIMEOUT - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    state_t        state_q, state_d;
    logic          valid_q, timeout_q;
    logic [3:0]    code_q;
    logic [15:0]   mask_q, mask_d, mask_set;
    logic [TW-1:0] timer_q;
    logic [SW-1:0] scan_q;
    logic [1:0]    digsel_q, digsel_d;
    logic [7:0]    seg_q, seg_dec;

    logic [15:0]   avail;
    logic [3:0]    pick_idx;
    logic          pick_any;
    logic          timer_tc;
    logic          do_grant, do_drop, do_mask, do_expire, timer_run;

    assign avail = ~ReqIn & ~mask_q;

    // Later iterations overwrite earlier ones, so the highest index wins
    always_comb begin
        pick_idx = 4'd0;
        pick_any = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (avail[i]) begin
                pick_idx = 4'(i);
                pick_any = 1'b1;
            end
        end
    end

    // Timer counts down from GRANT_TIMEOUT-1; terminal count at zero
    assign timer_tc = (timer_q == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!EI && pick_any) state_d = GRANT;
            GRANT: begin
                if (EI)                                 state_d = IDLE;
                else if (ReqIn[code_q] || Ack || timer_tc) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_grant  = 1'b0;
        do_drop   = 1'b0;
        do_mask   = 1'b0;
        do_expire = 1'b0;
        timer_run = 1'b0;
        case (state_q)
            IDLE: do_grant = !EI && pick_any;
            GRANT: begin
                if (EI || ReqIn[code_q]) begin
                    do_drop = 1'b1;
                end else if (Ack) begin
                    do_drop = 1'b1;
                    do_mask = 1'b1;
                end else if (timer_tc) begin
                    do_drop   = 1'b1;
                    do_mask   = 1'b1;
                    do_expire = 1'b1;
                end else begin
                    timer_run = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A deasserted request clears its mask bit even if it is being set now
    assign mask_set = do_mask ? (16'h0001 << code_q) : 16'h0000;
    assign mask_d   = (mask_q | mask_set) & ~ReqIn;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q   <= 1'b0;
            code_q    <= 4'd0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
            mask_q    <= '0;
        end else begin
            if (do_grant) begin
                valid_q <= 1'b1;
                code_q  <= pick_idx;
                timer_q <= TIMER_LOAD;
            end else if (do_drop) begin
                valid_q <= 1'b0;
            end else if (timer_run) begin
                timer_q <= timer_q - 1'b1;
            end
            timeout_q <= do_expire;
            mask_q    <= mask_d;
        end
    end

    logic       scan_wrap;
    logic [3:0] ones_bcd, tens_bcd, bcd_sel;

    assign scan_wrap = (scan_q == SCAN_LAST);
    assign digsel_d  = scan_wrap ? ~digsel_q : digsel_q;
    assign ones_bcd  = (code_q >= 4'd10) ? (code_q - 4'd10) : code_q;
    assign tens_bcd  = (code_q >= 4'd10) ? 4'd1 : BCD_BLANK;

    // Decode for the digit selected after this edge so Seg and DigSel switch together
    assign bcd_sel = !valid_q                  ? BCD_BLANK :
                     (digsel_d == DIGSEL_ONES) ? ones_bcd  : tens_bcd;

    seg7_decode u_seg7_decode (
        .bcd (bcd_sel),
        .seg (seg_dec)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_q   <= '0;
            digsel_q <= DIGSEL_ONES;
            seg_q    <= SEG_BLANK;
        end else begin
            scan_q   <= scan_wrap ? '0 : scan_q + 1'b1;
            digsel_q <= digsel_d;
            seg_q    <= seg_dec;
        end
    end

    assign Valid   = valid_q;
    assign Code    = code_q;
    assign Timeout = timeout_q;
    assign Seg     = seg_q;
    assign DigSel  = digsel_q;

endmodule

// File: tb/tb_req_scheduler16.sv
// Directed bench for req_scheduler16: grant/timeout events go through a
// scoreboard queue, cycle-level timing and display are checked inline.
module tb_req_scheduler16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EI;
    logic [15:0] ReqIn;
    logic        Ack;
    logic        Valid;
    logic [3:0]  Code;
    logic        Timeout;
    logic [7:0]  Seg;
    logic [1:0]  DigSel;

    always #5 CLK = ~CLK;

    req_scheduler16 #(.SCAN_DIV(4), .GRANT_TIMEOUT(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EI      (EI),
        .ReqIn   (ReqIn),
        .Ack     (Ack),
        .Valid   (Valid),
        .Code    (Code),
        .Timeout (Timeout),
        .Seg     (Seg),
        .DigSel  (DigSel)
    );

    typedef struct {
        bit         is_to;
        logic [3:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_grant(input logic [3:0] c);
        ev_t e;
        e.is_to = 1'b0;
        e.code  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_timeout(input logic [3:0] c);
        ev_t e;
        e.is_to = 1'b1;
        e.code  = c;
        exp_q.push_back(e);
    endtask

    // Monitor: a grant start or a Timeout pulse consumes the next expected event
    logic       prev_valid = 1'b0;
    logic [3:0] last_code  = 4'd0;
    always @(negedge CLK) begin
        ev_t ev;
        if (RST) begin
            prev_valid = 1'b0;
        end else begin
            if (Valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got code %0d, expected no event", Code);
                end else begin
                    ev = exp_q.pop_front();
                    chk("event_is_grant", {31'd0, ev.is_to}, 32'd0);
                    chk("grant_code", {28'd0, Code}, {28'd0, ev.code});
                end
                last_code = Code;
            end
            if (Timeout) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_timeout: got pulse, expected none");
                end else begin
                    ev = exp_q.pop_front();
                    chk("event_is_timeout", {31'd0, ev.is_to}, 32'd1);
                    chk("timeout_code", {28'd0, last_code}, {28'd0, ev.code});
                end
            end
            prev_valid = Valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int last_chg;
        int n_chg;
        logic [1:0] prev_ds;

        RST   = 1'b1;
        EI    = 1'b1;
        ReqIn = 16'hFFFF;
        Ack   = 1'b0;
        repeat (3) tick();
        chk("rst_valid",   {31'd0, Valid},   32'd0);
        chk("rst_code",    {28'd0, Code},    32'd0);
        chk("rst_timeout", {31'd0, Timeout}, 32'd0);
        chk("rst_seg",     {24'd0, Seg},     32'd0);
        chk("rst_digsel",  {30'd0, DigSel},  32'd2);
        RST = 1'b0;
        tick();

        // Bits 12 and 5 requesting: 12 first, then 5 after an Ack with 12 masked
        EI    = 1'b0;
        ReqIn = ~(16'h1000 | 16'h0020);
        push_grant(4'd12);
        tick();
        chk("a_grant_valid", {31'd0, Valid}, 32'd1);
        chk("a_grant_code",  {28'd0, Code},  32'd12);
        Ack = 1'b1;
        push_grant(4'd5);
        tick();
        Ack = 1'b0;
        chk("a_ack_drop", {31'd0, Valid}, 32'd0);
        tick();
        chk("a_gap2", {31'd0, Valid}, 32'd0);
        tick();
        chk("a_next_valid", {31'd0, Valid}, 32'd1);
        chk("a_next_code",  {28'd0, Code},  32'd5);

        // Pulsing bit 12 high clears its mask, so it wins again after 5 is acked
        ReqIn[12] = 1'b1;
        tick();
        ReqIn[12] = 1'b0;
        tick();
        Ack = 1'b1;
        push_grant(4'd12);
        tick();
        Ack = 1'b0;
        chk("b_ack_drop", {31'd0, Valid}, 32'd0);
        tick();
        tick();
        chk("b_regrant_valid", {31'd0, Valid}, 32'd1);
        chk("b_regrant_code",  {28'd0, Code},  32'd12);
        ReqIn = 16'hFFFF;
        tick();
        chk("b_withdraw_drop", {31'd0, Valid}, 32'd0);
        tick();
        tick();

        // Timeout: bit 3 held without Ack
        ReqIn = ~16'h0008;
        push_grant(4'd3);
        push_timeout(4'd3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Valid) cnt++;
            else if (cnt > 0) break;
        end
        chk("c_valid_cycles", cnt, 32'd8);
        chk("c_timeout_pulse", {31'd0, Timeout}, 32'd1);
        tick();
        chk("c_timeout_single", {31'd0, Timeout}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_masked_hold", {31'd0, Valid}, 32'd0);
        end
        ReqIn = 16'hFFFF;
        tick();
        ReqIn = ~16'h0008;
        push_grant(4'd3);
        tick();
        chk("c_regrant_valid", {31'd0, Valid}, 32'd1);
        chk("c_regrant_code",  {28'd0, Code},  32'd3);
        ReqIn = 16'hFFFF;
        tick();
        tick();

        // EI abort of bit 9: no Timeout, no mask
        ReqIn = ~16'h0200;
        push_grant(4'd9);
        tick();
        chk("d_grant_code", {28'd0, Code}, 32'd9);
        EI = 1'b1;
        tick();
        chk("d_abort_valid",   {31'd0, Valid},   32'd0);
        chk("d_abort_timeout", {31'd0, Timeout}, 32'd0);
        tick();
        chk("d_ei_block", {31'd0, Valid}, 32'd0);
        EI = 1'b0;
        push_grant(4'd9);
        tick();
        chk("d_regrant_valid", {31'd0, Valid}, 32'd1);
        chk("d_regrant_code",  {28'd0, Code},  32'd9);
        ReqIn = 16'hFFFF;
        tick();
        tick();

        // Display with Code=12 then Code=5 (each grant times out)
        ReqIn = ~16'h1000;
        push_grant(4'd12);
        push_timeout(4'd12);
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            if (DigSel == 2'b10) chk("e12_seg_ones", {24'd0, Seg}, 32'h5B);
            else                 chk("e12_seg_tens", {24'd0, Seg}, 32'h06);
        end
        tick();
        tick();
        chk("e12_seg_blank", {24'd0, Seg}, 32'h00);
        ReqIn = 16'hFFFF;
        tick();
        tick();
        ReqIn = ~16'h0020;
        push_grant(4'd5);
        push_timeout(4'd5);
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            if (DigSel == 2'b10) chk("e5_seg_ones", {24'd0, Seg}, 32'h6D);
            else                 chk("e5_seg_tens", {24'd0, Seg}, 32'h00);
        end
        tick();
        tick();
        chk("e5_seg_blank", {24'd0, Seg}, 32'h00);
        ReqIn = 16'hFFFF;

        // DigSel period, scanning continues with Valid low
        prev_ds  = DigSel;
        last_chg = -1;
        n_chg    = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DigSel != prev_ds) begin
                chk("f_digsel_code", {31'd0, (DigSel == 2'b10) || (DigSel == 2'b01)}, 32'd1);
                if (last_chg >= 0) chk("f_digsel_period", i - last_chg, 32'd4);
                last_chg = i;
                n_chg++;
                prev_ds  = DigSel;
            end
        end
        chk("f_digsel_toggles", n_chg, 32'd5);

        // Reset in the middle of a grant of bit 7
        ReqIn = ~16'h0080;
        push_grant(4'd7);
        tick();
        chk("g_grant_code", {28'd0, Code}, 32'd7);
        tick();
        #1 RST = 1'b1;
        #1;
        chk("g_rst_valid",   {31'd0, Valid},   32'd0);
        chk("g_rst_code",    {28'd0, Code},    32'd0);
        chk("g_rst_timeout", {31'd0, Timeout}, 32'd0);
        chk("g_rst_seg",     {24'd0, Seg},     32'd0);
        chk("g_rst_digsel",  {30'd0, DigSel},  32'd2);
        tick();
        RST   = 1'b0;
        ReqIn = 16'hFFFF;
        tick();
        tick();
        chk("g_post_digsel", {30'd0, DigSel}, 32'd2);
        chk("g_post_seg",    {24'd0, Seg},    32'd0);
        chk("g_post_valid",  {31'd0, Valid},  32'd0);

        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
